// File: rtl/fsl_to_stream_if.sv
// rtl/fsl_to_stream_if.sv - FSL result input and 128-bit host output stream bundle
interface fsl_to_stream_if;
  logic [31:0]  fsl_data;
  logic         fsl_valid;
  logic         fsl_afull;
  logic         s1o_valid;
  logic         s1o_rdy;
  logic [127:0] s1o_data;

  modport master (
    input  fsl_data, fsl_valid, s1o_rdy,
    output fsl_afull, s1o_valid, s1o_data
  );

  modport slave (
    output fsl_data, fsl_valid, s1o_rdy,
    input  fsl_afull, s1o_valid, s1o_data
  );
endinterface

// File: rtl/fsl_to_stream.sv
// rtl/fsl_to_stream.sv - assembles 5x32-bit FSL words into 160-bit records, buffers them, emits two 128-bit beats each
module fsl_to_stream #(
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fsl_to_stream_if.master     bus,
  output logic [31:0]         rec_count,
  output logic                overflow,
  output logic                frag_err
);
  localparam int AW  = $clog2(DEPTH);
  localparam int THR = DEPTH - AFULL_MARGIN;

  typedef enum logic [1:0] {IDLE, HI, LO} state_t;

  state_t         state;
  logic [2:0]     wpos;
  logic [159:0]   shreg;
  logic           rec_done;
  logic [159:0]   mem [DEPTH];
  logic [AW:0]    wptr;
  logic [AW:0]    rptr;
  logic [AW:0]    occ;
  logic           full;
  logic           empty;
  logic           more;
  logic           wr_en;
  logic [AW-1:0]  next_idx;
  logic [159:0]   head;
  logic [159:0]   next_rec;

  assign occ      = wptr - rptr;
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty    = (wptr == rptr);
  assign more     = occ > (AW+1)'(1);
  assign wr_en    = rec_done && !full;
  assign next_idx = rptr[AW-1:0] + AW'(1);
  assign head     = mem[rptr[AW-1:0]];
  assign next_rec = mem[next_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr[AW-1:0]] <= shreg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      wpos          <= 3'd0;
      shreg         <= '0;
      rec_done      <= 1'b0;
      wptr          <= '0;
      rptr          <= '0;
      rec_count     <= 32'd0;
      overflow      <= 1'b0;
      frag_err      <= 1'b0;
      bus.fsl_afull <= 1'b0;
      bus.s1o_valid <= 1'b0;
      bus.s1o_data  <= '0;
    end else begin
      // The completed record stays in shreg for exactly one cycle while the next one starts shifting in.
      rec_done <= bus.fsl_valid && (wpos == 3'd4);
      if (bus.fsl_valid) begin
        shreg <= {shreg[127:0], bus.fsl_data};
        wpos  <= (wpos == 3'd4) ? 3'd0 : wpos + 3'd1;
      end else if (wpos != 3'd0) begin
        wpos     <= 3'd0;
        frag_err <= 1'b1;
      end

      if (rec_done) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          wptr <= wptr + (AW+1)'(1);
        end
      end

      bus.fsl_afull <= occ >= (AW+1)'(THR);

      case (state)
        IDLE: begin
          if (!empty) begin
            bus.s1o_data  <= {1'b0, 31'h0, head[159:64]};
            bus.s1o_valid <= 1'b1;
            state         <= HI;
          end
        end
        HI: begin
          if (bus.s1o_rdy) begin
            bus.s1o_data <= {1'b1, 63'h0, head[63:0]};
            state        <= LO;
          end
        end
        LO: begin
          // The entry leaves the FIFO only once its second beat is accepted.
          if (bus.s1o_rdy) begin
            rptr      <= rptr + (AW+1)'(1);
            rec_count <= rec_count + 32'd1;
            if (more) begin
              bus.s1o_data <= {1'b0, 31'h0, next_rec[159:64]};
              state        <= HI;
            end else begin
              bus.s1o_valid <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        default: begin
          bus.s1o_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/fsl_to_stream.md
Name: fsl_to_stream

Overview:
- Return-path stage directly downstream of the FSL cracking cores.
- Deserializes 32-bit FSL result words, MSW first, into 160-bit records and buffers them in an internal record FIFO.
- Emits each record as two 128-bit beats on the host output stream with a valid/rdy handshake.
- Reports back-pressure, overflow and framing errors plus a record counter to the status path.

Parameters:
- DEPTH, 16: record FIFO depth in 160-bit entries; power of two, at least 4.
- AFULL_MARGIN, 4: fsl_afull asserts when occupancy >= DEPTH-AFULL_MARGIN.

Ports:
- clk  input  1  single clock for the whole block.
- rst_n  input  1  reset; synchronous, active-low.
- fsl_data  input  32  FSL result word.
- fsl_valid  input  1  qualifies fsl_data. A record is 5 consecutive valid cycles, MSW first.
- fsl_afull  output  1  almost-full back-pressure to the FSL side.
- s1o_valid  output  1  output beat valid.
- s1o_rdy  input  1  downstream ready.
- s1o_data  output  128  output beat.
- rec_count  output  32  records fully emitted on s1o.
- overflow  output  1  sticky: a completed record was dropped because the FIFO was full.
- frag_err  output  1  sticky: fsl_valid dropped mid-record.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all state:
  - word position, FIFO pointers, output FSM, rec_count, overflow, frag_err.
  - fsl_afull=0, s1o_valid=0, s1o_data=0.
  - A partial record or an in-flight beat is discarded; nothing is emitted after reset releases.
- Assembly:
  - A 3-bit word position wpos runs 0..4. Each fsl_valid cycle shifts the word into a 160-bit shift register from the LSW side, so the first word ends up in [159:128].
  - On fsl_valid with wpos=4, the record is complete and wpos returns to 0.
  - If fsl_valid=0 while wpos!=0: discard the partial record, set wpos=0, set frag_err.
  - A new record may start in the cycle right after the previous one completes; back-to-back records are sustained.
- FIFO write:
  - Occurs in the cycle after completion.
  - If the FIFO is full at that time, the record is dropped and overflow is set. Pointers are unchanged.
  - Write and read in the same cycle are allowed and leave occupancy unchanged. Full and empty are distinguished by an extra pointer bit.
- fsl_afull is registered: asserted one cycle after occupancy reaches DEPTH-AFULL_MARGIN, cleared one cycle after it drops below.
- Output FSM states: IDLE, HI, LO.
  - IDLE: if the FIFO is non-empty, load s1o_data = {1'b0, 31'h0, rec[159:64]}, set s1o_valid=1, go to HI.
  - HI: on s1o_valid & s1o_rdy, load s1o_data = {1'b1, 63'h0, rec[63:0]}, keep s1o_valid=1, go to LO.
  - LO: on s1o_valid & s1o_rdy:
    - pop the FIFO entry (it is popped only here, not when it is loaded) and increment rec_count (wraps at 2^32);
    - if the FIFO holds another entry, load its HI beat and go to HI; otherwise clear s1o_valid and go to IDLE.
  - s1o_data and s1o_valid hold stable while s1o_valid & !s1o_rdy.
- Latency: last FSL word at cycle N produces the FIFO write at N+1 and the HI beat valid at N+3 if the FIFO was empty.
- Peak throughput: 1 record per 2 cycles out, 1 per 5 cycles in; the FIFO drains faster than it fills when s1o_rdy=1.

Test Plan:
- Basic path: send 5 words 0x11111111..0x55555555 with s1o_rdy=1.
  - Response: HI beat = {1'b0, 31'h0, 0x11111111_22222222_33333333} at N+3, then LO beat = {1'b1, 63'h0, 0x44444444_55555555}; rec_count=1.
- Framing error: 3 valid words, one idle cycle, then 5 words A0..A4.
  - Response: frag_err=1; exactly one record is emitted and it carries A0..A4.
- Back-pressure: s1o_rdy=0 while 12 records stream in.
  - Response: fsl_afull=1 once occupancy reaches 12; s1o_valid=1 with s1o_data frozen on the first HI beat; no overflow.
- Overflow: keep s1o_rdy=0 and send 17 records.
  - Response: overflow=1; after s1o_rdy=1, exactly 16 records drain in order; rec_count=16.
- Reset mid-operation: assert rst_n=0 with the FSM in LO and wpos=2.
  - Response: next cycle s1o_valid=0, rec_count=0, flags=0; a subsequent full record emits normally.
- Random stress: random s1o_rdy at 50%, 200 back-to-back records.
  - Response: the scoreboard matches all records in order; rec_count=200; no frag_err or overflow.
